pipeline_elastic: RTL and testbench

- Parametrised successor to the fixed 5-deep pipeFlow pipeline.
- Elastic valid/ready register pipeline, WIDTH bits wide and DEPTH stages deep.
- Adds per-stage valid tracking with bubble collapse, a synchronous flush, and an occupancy count.
- Sits between any valid/ready producer and consumer in the pipeFlow datapath.

---
 rtl/pipeline_elastic_pkg.sv | 19 +
 rtl/pipeline_elastic_pipe_stage.sv | 43 ++++
 rtl/pipeline_elastic.sv | 135 +++++++++++++
 tb/tb_pipeline_elastic.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_elastic_pkg.sv
// Shared types and helpers for the pipeFlow elastic pipeline.
// Also carries the legacy pipeFlow depth macro for older blocks.
`ifndef pipeFlow
`define pipeFlow 5
`endif

package pipeFlow_pkg;

  typedef struct packed {
    logic valid;
    logic rdy;
  } pipe_ctl_t;

  // Width of a counter spanning 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_elastic_pipe_stage.sv
// One elastic pipeline stage: valid bit plus WIDTH-bit data register.
// Data is only overwritten when a valid slot arrives; flush clears valid only.
module pipe_stage #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_elastic.sv
// DEPTH-stage elastic valid/ready pipeline with bubble collapse, flush and occupancy count.
// Define PIPEFLOW_SKID_EN to add a one-entry skid so pipe_in_rdy comes straight from a flop.
module pipeline_elastic
  import pipeFlow_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        flush_i,
  input  logic [WIDTH-1:0]            input_val,
  input  logic                        pipe_in_valid,
  output logic                        pipe_in_rdy,
  output logic [WIDTH-1:0]            output_val,
  output logic                        pipe_out_valid,
  input  logic                        pipe_out_rdy,
`ifdef PIPEFLOW_SKID_EN
  output logic [cnt_w(DEPTH+1)-1:0]   count_o
`else
  output logic [cnt_w(DEPTH)-1:0]     count_o
`endif
);

`ifdef PIPEFLOW_SKID_EN
  localparam int unsigned CW = cnt_w(DEPTH + 1);
`else
  localparam int unsigned CW = cnt_w(DEPTH);
`endif

  logic             v    [DEPTH];
  logic [WIDTH-1:0] dat  [DEPTH];
  logic             up_v [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  pipe_ctl_t        ctl  [DEPTH];
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic             in_xfer, out_xfer;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Ready ripples back from the consumer; an empty stage is always ready.
  always_comb begin : ready_chain
    logic nxt;
    nxt = pipe_out_rdy;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ctl[DEPTH-1-i].valid = v[DEPTH-1-i];
      ctl[DEPTH-1-i].rdy   = !ctl[DEPTH-1-i].valid | nxt;
      nxt                  = ctl[DEPTH-1-i].rdy;
    end
  end

  always_comb begin
    up_v[0] = s0_valid;
    up_d[0] = s0_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = dat[i-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .flush_i (flush_i),
      .en_i    (ctl[k].rdy),
      .valid_i (up_v[k]),
      .data_i  (up_d[k]),
      .valid_o (v[k]),
      .data_o  (dat[k])
    );
  end

`ifdef PIPEFLOW_SKID_EN
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;

  assign pipe_in_rdy = !skid_v_q & !flush_i;
  assign in_xfer     = pipe_in_valid & pipe_in_rdy;
  // A parked skid entry owns stage 0's input until it drains.
  assign s0_valid    = skid_v_q | pipe_in_valid;
  assign s0_data     = skid_v_q ? skid_d_q : input_val;

  always_comb begin
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush_i) begin
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (ctl[0].rdy) skid_v_d = 1'b0;
    end else if (in_xfer && !ctl[0].rdy) begin
      skid_v_d = 1'b1;
      skid_d_d = input_val;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
    end
  end
`else
  assign pipe_in_rdy = ctl[0].rdy & !flush_i;
  assign in_xfer     = pipe_in_valid & pipe_in_rdy;
  assign s0_valid    = pipe_in_valid;
  assign s0_data     = input_val;
`endif

  assign output_val     = dat[DEPTH-1];
  assign pipe_out_valid = ctl[DEPTH-1].valid & !flush_i;
  assign out_xfer       = pipe_out_valid & pipe_out_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (in_xfer && !out_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end else if (out_xfer && !in_xfer) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: tb/tb_pipeline_elastic.sv
// Self-checking bench for pipeline_elastic (WIDTH=5, DEPTH=5), with or without PIPEFLOW_SKID_EN.
module tb_pipeline_elastic;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 5;
`ifdef PIPEFLOW_SKID_EN
  localparam int unsigned CAP = DEPTH + 1;
  localparam bit          SKID = 1'b1;
`else
  localparam int unsigned CAP = DEPTH;
  localparam bit          SKID = 1'b0;
`endif
  localparam int unsigned CW = $clog2(CAP + 1);
  localparam int          D  = DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_rdy = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_rdy;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] data;
    logic             out_rdy;
    logic             exp_in_rdy;
    logic             exp_out_valid;
    logic [WIDTH-1:0] exp_out_val;
    int               exp_count;
  } vec_t;

  vec_t tbl [16];

  // Reference model: one entry per item in flight, oldest first, with its stage index (-1 = skid).
  int               mpos [$];
  logic [WIDTH-1:0] mdat [$];
  int               npos [$];
  int               prev, new_pos, bias, got, lat;
  logic             exp_rdy, exp_ov, take;
  logic [WIDTH-1:0] seen [$];

  always #5 clk = ~clk;

  pipeline_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .flush_i       (flush),
    .input_val     (in_data),
    .pipe_in_valid (in_valid),
    .pipe_in_rdy   (in_rdy),
    .output_val    (out_data),
    .pipe_out_valid(out_valid),
    .pipe_out_rdy  (out_rdy),
    .count_o       (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    out_rdy  = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming vectors: push 1..8 back-to-back, consumer always ready.
    for (int c = 0; c < 16; c++) begin
      tbl[c].flush         = 1'b0;
      tbl[c].in_valid      = (c < 8);
      tbl[c].data          = (c < 8) ? WIDTH'(c + 1) : '0;
      tbl[c].out_rdy       = 1'b1;
      tbl[c].exp_in_rdy    = 1'b1;
      tbl[c].exp_out_valid = (c >= 5 && c <= 12);
      tbl[c].exp_out_val   = WIDTH'(c - 4);
      tbl[c].exp_count     = ((c < 8) ? c : 8) - ((c < 5) ? 0 : ((c - 5 > 8) ? 8 : c - 5));
    end

    // Reset state, sampled while reset is held.
    #2;
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_val", out_data, 0);
    check("rst_count", count, 0);
    do_reset();

    for (int c = 0; c < 16; c++) begin
      flush    = tbl[c].flush;
      in_valid = tbl[c].in_valid;
      in_data  = tbl[c].data;
      out_rdy  = tbl[c].out_rdy;
      @(negedge clk);
      check("stream_in_rdy", in_rdy, tbl[c].exp_in_rdy);
      check("stream_out_valid", out_valid, tbl[c].exp_out_valid);
      if (tbl[c].exp_out_valid) check("stream_out_val", out_data, tbl[c].exp_out_val);
      check("stream_count", count, tbl[c].exp_count);
      next_cycle();
    end

    // Backpressure: fill to full with the consumer stalled, then drain.
    do_reset();
    out_rdy = 1'b0;
    for (int i = 1; i <= D; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      @(negedge clk);
      check("bp_fill_in_rdy", in_rdy, 1);
      next_cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_in_rdy", in_rdy, SKID ? 1 : 0);
      check("bp_full_count", count, D);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_val", out_data, 1);
      next_cycle();
    end
    if (SKID) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(6);
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      check("skid_in_rdy", in_rdy, 0);
      check("skid_count", count, D + 1);
      check("skid_hold_val", out_data, 1);
      next_cycle();
    end
    out_rdy = 1'b1;
    seen.delete();
    for (int i = 0; i < 4 * D; i++) begin
      @(negedge clk);
      if (out_valid) seen.push_back(out_data);
      next_cycle();
    end
    check("bp_drain_n", seen.size(), CAP);
    for (int i = 0; i < seen.size(); i++) check("bp_drain_order", seen[i], i + 1);
    @(negedge clk);
    check("bp_drain_count", count, 0);
    next_cycle();

    // Bubble collapse: 7, three idle cycles, 9, consumer stalled.
    do_reset();
    out_rdy  = 1'b0;
    in_valid = 1'b1;
    in_data  = WIDTH'(7);
    next_cycle();
    idle_cycles(3);
    in_valid = 1'b1;
    in_data  = WIDTH'(9);
    next_cycle();
    idle_cycles(3);
    @(negedge clk);
    check("bub_count", count, 2);
    check("bub_out_valid", out_valid, 1);
    check("bub_out_val", out_data, 7);
    next_cycle();
    out_rdy = 1'b1;
    @(negedge clk);
    check("bub_first_val", out_data, 7);
    next_cycle();
    @(negedge clk);
    check("bub_second_valid", out_valid, 1);
    check("bub_second_val", out_data, 9);
    next_cycle();
    @(negedge clk);
    check("bub_empty_valid", out_valid, 0);
    check("bub_empty_count", count, 0);
    next_cycle();

    // Flush with three values in flight; an offered input during flush is refused.
    do_reset();
    out_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      next_cycle();
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = WIDTH'(13);
    @(negedge clk);
    check("flush_in_rdy", in_rdy, 0);
    check("flush_out_valid", out_valid, 0);
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_valid", out_valid, 0);
    check("post_flush_count", count, 0);
    got = 0;
    for (int i = 0; i < D + 2; i++) begin
      @(negedge clk);
      if (out_valid) got++;
      next_cycle();
    end
    check("flush_no_stale", got, 0);
    in_valid = 1'b1;
    in_data  = WIDTH'(4);
    @(negedge clk);
    check("flush_push_rdy", in_rdy, 1);
    next_cycle();
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 3 * D && lat < 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        check("flush_push_val", out_data, 4);
      end
      next_cycle();
    end
    check("flush_push_latency", lat, D);

    // Asynchronous reset between edges while four values are held.
    do_reset();
    out_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i + 20);
      next_cycle();
    end
    idle_cycles(1);
    #1;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_count", count, 4);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_count", count, 0);
    check("async_rst_val", out_data, 0);
    check("async_rst_in_rdy", in_rdy, 1);
    next_cycle();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    got = 0;
    for (int i = 0; i < 2 * D; i++) begin
      @(negedge clk);
      if (out_valid) got++;
      next_cycle();
    end
    check("rst_no_stale", got, 0);

    // Randomized traffic against the position-based reference model.
    do_reset();
    mpos.delete();
    mdat.delete();
    bias = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) bias = $urandom_range(0, 4);
      flush    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = WIDTH'($urandom);
      out_rdy  = ($urandom_range(0, 3) < bias);

      npos.delete();
      prev = D + 1;
      for (int i = 0; i < mpos.size(); i++) begin
        int q;
        if (i == 0) q = (mpos[i] == D - 1) ? (out_rdy ? D : D - 1) : mpos[i] + 1;
        else        q = (mpos[i] + 1 < prev - 1) ? mpos[i] + 1 : prev - 1;
        npos.push_back(q);
        prev = q;
      end
      new_pos = (prev - 1 < 0) ? prev - 1 : 0;
      if (SKID) exp_rdy = !flush && !(mpos.size() > 0 && mpos[mpos.size()-1] == -1);
      else      exp_rdy = !flush && (new_pos == 0);
      exp_ov = !flush && mpos.size() > 0 && mpos[0] == D - 1;

      @(negedge clk);
      check("rnd_in_rdy", in_rdy, exp_rdy);
      check("rnd_out_valid", out_valid, exp_ov);
      if (exp_ov) check("rnd_out_val", out_data, mdat[0]);
      check("rnd_count", count, mpos.size());

      @(posedge clk);
      if (flush) begin
        mpos.delete();
        mdat.delete();
      end else begin
        take = in_valid && exp_rdy;
        for (int i = 0; i < npos.size(); i++) mpos[i] = npos[i];
        if (npos.size() > 0 && npos[0] == D) begin
          void'(mpos.pop_front());
          void'(mdat.pop_front());
        end
        if (take) begin
          mpos.push_back(new_pos);
          mdat.push_back(in_data);
        end
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
